// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access
// widths, the ResultSrc value that marks a load, and the LSU state encoding.
package mem_stage_lsu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ResultSrc value that selects memory data, i.e. a load in MEM
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Halfword accesses (signed or unsigned) need addr[0] clear
    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational data alignment for the LSU: store lane replication and byte
// enables, misalignment detection, and load byte/half extraction with
// sign or zero extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic        is_mem,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_rep;
    logic [3:0]  byte_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte stores: the low byte is copied to every lane, one enable per lane
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_rep[gi*8 +: 8] = store_data[7:0];
            assign byte_strb[gi]       = (addr_lo == 2'(gi));
        end
    endgenerate

    // Store data and byte enables by access width
    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = byte_rep;
                wstrb = byte_strb;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    // A halfword must sit on an even address, a word on a multiple of four
    always_comb begin
        misaligned = is_mem & ((is_half(funct3) & addr_lo[0]) |
                               ((funct3 == F3_W) & (addr_lo != 2'b00)));
    end

    // Load extraction uses the offset and width captured at issue time
    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_addr_lo)
            2'b00:   ld_byte = rdata[7:0];
            2'b01:   ld_byte = rdata[15:8];
            2'b10:   ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Issues each aligned load/store from the
// EX/MEM register as a valid/ready request, stalls the pipeline until it
// completes, and registers extended load data for MEM/WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic            MisalignedM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t  state_reg, state_next;
    logic [2:0]  ld_funct3_reg;
    logic [1:0]  ld_off_reg;
    logic        is_load;
    logic        is_mem;
    logic        access;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_ld_data;

    assign is_load = (ResultSrcM == RESULT_SRC_LOAD);
    assign is_mem  = MemWriteM | is_load;
    assign access  = is_mem & ~MisalignedM;

    mem_stage_lsu_align u_align (
        .is_mem     (is_mem),
        .funct3     (funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .misaligned (MisalignedM),
        .ld_funct3  (ld_funct3_reg),
        .ld_addr_lo (ld_off_reg),
        .rdata      (mem_rdata),
        .ld_data    (al_ld_data)
    );

    // Stall covers the issue cycle and every wait state; DONE lets the pipe advance
    assign StallM        = ((state_reg == LSU_IDLE) & access) |
                           (state_reg == LSU_REQ) | (state_reg == LSU_RESP);
    assign mem_req_valid = (state_reg == LSU_REQ);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LSU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; responses outside RESP are ignored
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (access)        state_next = LSU_REQ;
            LSU_REQ:  if (mem_req_ready) state_next = mem_we ? LSU_DONE : LSU_RESP;
            LSU_RESP: if (mem_rsp_valid) state_next = LSU_DONE;
            default:                     state_next = LSU_IDLE;
        endcase
    end

    // Request fields latched at issue and held through REQ; load data captured in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= 4'b0000;
            ld_funct3_reg <= 3'b000;
            ld_off_reg    <= 2'b00;
            ReadDataM     <= '0;
        end else begin
            if ((state_reg == LSU_IDLE) && access) begin
                mem_we        <= MemWriteM;
                mem_addr      <= {ALUResultM[XLEN-1:2], 2'b00};
                mem_wdata     <= MemWriteM ? al_wdata : '0;
                mem_wstrb     <= MemWriteM ? al_wstrb : 4'b0000;
                ld_funct3_reg <= funct3M;
                ld_off_reg    <= ALUResultM[1:0];
            end
            if ((state_reg == LSU_RESP) && mem_rsp_valid) begin
                ReadDataM <= al_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by
// randomized loads/stores against a transaction-level reference model.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic        MisalignedM;
    logic [31:0] ReadDataM;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int          total = 0;
    int          bad = 0;
    int          txn_no = 0;
    logic [31:0] model_rd;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemWriteM     (MemWriteM),
        .ResultSrcM    (ResultSrcM),
        .funct3M       (funct3M),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .StallM        (StallM),
        .MisalignedM   (MisalignedM),
        .ReadDataM     (ReadDataM),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---- reference model: access rules expressed with plain arithmetic ----
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (size_of(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (size_of(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] one_b;
        logic [3:0] two_b;
        one_b = 4'b0001;
        two_b = 4'b0011;
        if (size_of(f3) == 1) return one_b << addr[1:0];
        if (size_of(f3) == 2) return two_b << addr[1:0];
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] mask;
        logic [31:0] v;
        int          sz;
        sz = size_of(f3);
        if (sz == 4) return rd;
        sh   = rd >> (8 * int'(addr[1:0]));
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v    = sh & mask;
        if (!f3[2] && (((sz == 1) && v[7]) || ((sz == 2) && v[15]))) v = v | ~mask;
        return v;
    endfunction

    // Clear the pipeline-side inputs to a non-memory instruction
    task automatic drive_idle();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'($urandom);
        ALUResultM = $urandom;
        WriteDataM = $urandom;
    endtask

    // One load/store through the LSU with a simple responder. Entered and left
    // just after a rising edge.
    task automatic run_txn(input bit is_st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int dready, input int drsp);
        bit   exp_mis;
        int   stalls;
        int   req_seen;
        int   after;
        bit   accepted;
        bit   done;
        int   exp_stalls;
        MemWriteM     = is_st;
        ResultSrcM    = is_st ? 2'b00 : 2'b01;
        funct3M       = f3;
        ALUResultM    = addr;
        WriteDataM    = wd;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        exp_mis       = model_mis(f3, addr);
        txn_no++;
        @(negedge clk);
        check_val("misaligned", 32'(MisalignedM), 32'(exp_mis));
        if (exp_mis) begin
            check_val("mis_stall", 32'(StallM), 32'd0);
            check_val("mis_valid", 32'(mem_req_valid), 32'd0);
            @(posedge clk); #1;
            check_val("mis_valid_next", 32'(mem_req_valid), 32'd0);
            check_val("mis_readdata", ReadDataM, model_rd);
            $display("txn %0d %s f3=%0d addr=%h misaligned, skipped", txn_no,
                     is_st ? "st" : "ld", f3, addr);
            drive_idle();
            return;
        end
        stalls   = 0;
        req_seen = 0;
        after    = 0;
        accepted = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c != 0) @(negedge clk);
            if (!StallM) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req_valid) begin
                check_val("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check_val("req_we", 32'(mem_we), 32'(is_st));
                check_val("req_wstrb", 32'(mem_wstrb), is_st ? 32'(model_wstrb(f3, addr)) : 32'd0);
                if (is_st) check_val("req_wdata", mem_wdata, model_wdata(f3, wd));
            end
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            if (mem_req_valid) begin
                req_seen++;
                if (req_seen > dready) begin
                    mem_req_ready = 1'b1;
                    accepted      = 1'b1;
                end else if ($urandom_range(2) == 0) begin
                    mem_rsp_valid = 1'b1;
                end
            end else if (accepted && !is_st) begin
                after++;
                if (after == drsp + 1) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rd;
                end
            end
        end
        if (!done) begin
            check_val("txn_timeout", 32'd1, 32'd0);
            rst = 1'b1;
            #1 rst = 1'b0;
            model_rd = 32'd0;
        end
        exp_stalls = is_st ? dready + 2 : dready + drsp + 3;
        if (!is_st) model_rd = model_load(f3, addr, rd);
        check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check_val("done_valid", 32'(mem_req_valid), 32'd0);
        check_val("readdata", ReadDataM, model_rd);
        $display("txn %0d %s f3=%0d addr=%h wd=%h rd=%h stalls=%0d readdata=%h", txn_no,
                 is_st ? "st" : "ld", f3, addr, wd, rd, stalls, ReadDataM);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        drive_idle();
        #1;
        check_val("no_reissue_valid", 32'(mem_req_valid), 32'd0);
        check_val("no_reissue_stall", 32'(StallM), 32'd0);
    endtask

    // A cycle with no memory instruction in MEM
    task automatic bubble();
        drive_idle();
        @(negedge clk);
        check_val("bubble_stall", 32'(StallM), 32'd0);
        check_val("bubble_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // Reset while a load waits for its response, then a stale response in IDLE
    task automatic reset_in_resp();
        MemWriteM     = 1'b0;
        ResultSrcM    = 2'b01;
        funct3M       = 3'b010;
        ALUResultM    = 32'h0000_0040;
        WriteDataM    = 32'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check_val("rst_pre_stall", 32'(StallM), 32'd1);
        check_val("rst_pre_valid", 32'(mem_req_valid), 32'd0);
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        model_rd = 32'd0;
        check_val("rst_valid", 32'(mem_req_valid), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check_val("rst_readdata", ReadDataM, 32'd0);
        check_val("rst_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        check_val("stale_stall", 32'(StallM), 32'd0);
        check_val("stale_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check_val("stale_readdata", ReadDataM, 32'd0);
        $display("txn reset during RESP, stale response ignored");
    endtask

    initial begin
        logic [2:0] st_f3 [3];
        logic [2:0] ld_f3 [5];
        st_f3 = '{3'b000, 3'b001, 3'b010};
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        model_rd      = 32'd0;
        drive_idle();
        repeat (2) @(negedge clk);
        check_val("reset_valid", 32'(mem_req_valid), 32'd0);
        check_val("reset_we", 32'(mem_we), 32'd0);
        check_val("reset_addr", mem_addr, 32'd0);
        check_val("reset_wdata", mem_wdata, 32'd0);
        check_val("reset_wstrb", 32'(mem_wstrb), 32'd0);
        check_val("reset_readdata", ReadDataM, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0, 0);
        run_txn(1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_FF7F, 0, 0);
        check_val("lb_value", ReadDataM, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_FF7F, 0, 0);
        check_val("lbu_value", ReadDataM, 32'h0000_0080);
        run_txn(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'd0, 0, 0);
        run_txn(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0, 0);
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 5, 3);
        check_val("lw_slow_value", ReadDataM, 32'hCAFE_F00D);
        reset_in_resp();
        run_txn(1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'h0BAD_C0DE, 0, 0);
        check_val("lw_after_reset", ReadDataM, 32'h0BAD_C0DE);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit          is_st;
            logic [2:0]  f3;
            logic [31:0] addr;
            is_st = 1'($urandom);
            f3    = is_st ? st_f3[$urandom_range(2)] : ld_f3[$urandom_range(4)];
            addr  = $urandom;
            if ($urandom_range(9) < 7) addr = addr & ~(32'(size_of(f3)) - 32'd1);
            run_txn(is_st, f3, addr, $urandom, $urandom,
                    int'($urandom_range(4)), int'($urandom_range(4)));
            if ($urandom_range(3) == 0) bubble();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
